// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  localparam logic [3:0] PC_REG = 4'd15;

  // M has the youngest result, so it wins over W; R15 always reads PC+8.
  function automatic fwd_sel_t fwd_select(
    input logic [3:0] src,
    input logic [3:0] wa3m,
    input logic       we_m,
    input logic [3:0] wa3w,
    input logic       we_w
  );
    fwd_sel_t sel;
    sel = FWD_NONE;
    if (src != PC_REG) begin
      if (we_m && (wa3m == src))      sel = FWD_M;
      else if (we_w && (wa3w == src)) sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mul_seq_counter.sv
// Busy counter for a multiply held in Execute; busy lasts lat-1 cycles after start.
module mul_seq_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] lat,
  output logic       busy
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // A start while already counting is dropped; lat of 0 or 1 never loads.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 4'd0)              cnt_d = cnt_q - 4'd1;
    else if (start && (lat > 4'd1)) cnt_d = lat - 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, flush and forwarding control for the five-stage pipeline, plus a
// multiply sequencer and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MulStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCycles
);

  logic     mul_busy_raw;
  logic     busy;
  logic     ldr_stall;
  logic     pc_pend;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  mul_seq_counter u_mul_seq (
    .clk   (clk),
    .reset (reset),
    .start (MulStartE),
    .lat   (4'(MUL_LAT)),
    .busy  (mul_busy_raw)
  );

  // Every output is forced to its reset value combinationally while reset is low.
  assign busy      = reset & mul_busy_raw;
  assign ldr_stall = reset & MemtoRegE & RegWriteE & (WA3E != PC_REG) &
                     ((RA1D == WA3E) | (RA2D == WA3E));
  assign pc_pend   = reset & (PCSrcD | PCSrcE | PCSrcM);

  assign fwd_a = reset ? fwd_select(RA1E, WA3M, RegWriteM, WA3W, RegWriteW) : FWD_NONE;
  assign fwd_b = reset ? fwd_select(RA2E, WA3M, RegWriteM, WA3W, RegWriteW) : FWD_NONE;

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  assign StallF  = ldr_stall | pc_pend | busy;
  assign StallD  = ldr_stall | busy;
  assign StallE  = busy;
  assign MulBusy = busy;
  assign FlushM  = busy;
  assign FlushD  = ~reset | pc_pend | PCSrcW | BranchTakenE;
  // A busy multiply must never be bubbled out of Execute.
  assign FlushE  = ~reset | ((ldr_stall | BranchTakenE) & ~busy);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCycles = reset ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int          SAT     = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .BranchTakenE (BranchTakenE),
    .MulStartE    (MulStartE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .MulBusy      (MulBusy),
    .StallCycles  (StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MulStartE = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_load_use();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    RA1E = 4'd3; RA2E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    PCSrcD = 1'b1; MulStartE = 1'b1;
    set_load_use();
    tick();
    @(negedge clk);
    checks++;
    if ({StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, MulBusy} !== 11'b000_110_00_00_0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, MulBusy}, 11'b000_110_00_00_0);
    end
    checks++;
    if (StallCycles !== '0) begin
      errors++;
      $display("FAIL reset_stall_cycles: got %0d want 0", StallCycles);
    end
    tick();
    reset = 1'b1;
    idle();
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_a [3];
    logic [1:0] exp_b [3];
    exp_a[0] = 2'b10; exp_a[1] = 2'b01; exp_a[2] = 2'b00;
    exp_b[0] = 2'b10; exp_b[1] = 2'b01; exp_b[2] = 2'b01;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      RA1E = (k == 2) ? 4'd15 : 4'd3;
      RA2E = 4'd3;
      WA3M = 4'd3; RegWriteM = (k == 0);
      WA3W = 4'd3; RegWriteW = 1'b1;
      @(negedge clk);
      checks++;
      if (ForwardAE !== exp_a[k]) begin
        errors++;
        $display("FAIL fwd_a_%0d: got %b want %b", k, ForwardAE, exp_a[k]);
      end
      checks++;
      if (ForwardBE !== exp_b[k]) begin
        errors++;
        $display("FAIL fwd_b_%0d: got %b want %b", k, ForwardBE, exp_b[k]);
      end
      tick();
    end
    idle();
    RA1E = 4'd15; WA3M = 4'd15; RegWriteM = 1'b1; WA3W = 4'd15; RegWriteW = 1'b1;
    @(negedge clk);
    checks++;
    if (ForwardAE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_r15: got %b want 00", ForwardAE);
    end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
      errors++;
      $display("FAIL ldr_stall_cycle: got %b want 1110", {StallF, StallD, FlushE, StallE});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++;
      $display("FAIL ldr_released: got %b want 000", {StallF, StallD, FlushE});
    end
    checks++;
    if (StallCycles !== CNT_W'(1)) begin
      errors++;
      $display("FAIL ldr_stall_count: got %0d want 1", StallCycles);
    end
    tick();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd15; RA1D = 4'd15;
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++;
      $display("FAIL ldr_r15_ignored: got %b want 000", {StallF, StallD, FlushE});
    end
    tick();
    idle();
  endtask

  task automatic test_branch();
    int sf;
    int fd;
    do_reset();
    BranchTakenE = 1'b1;
    @(negedge clk);
    checks++;
    if ({FlushD, FlushE, StallF} !== 3'b110) begin
      errors++;
      $display("FAIL branch_resolve: got %b want 110", {FlushD, FlushE, StallF});
    end
    tick();
    sf = 0;
    fd = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      PCSrcD = (k == 0); PCSrcE = (k == 1); PCSrcM = (k == 2); PCSrcW = (k == 3);
      @(negedge clk);
      sf += int'(StallF);
      fd += int'(FlushD);
      if (k == 3) begin
        checks++;
        if (StallF !== 1'b0) begin
          errors++;
          $display("FAIL branch_stall_release: got %b want 0", StallF);
        end
      end
      tick();
    end
    checks++;
    if (sf != 3) begin
      errors++;
      $display("FAIL branch_stallf_cycles: got %0d want 3", sf);
    end
    checks++;
    if (fd != 4) begin
      errors++;
      $display("FAIL branch_flushd_cycles: got %0d want 4", fd);
    end
    idle();
  endtask

  task automatic test_multiply();
    logic b;
    do_reset();
    set_load_use();
    for (int k = 0; k < 6; k++) begin
      MulStartE = (k < 2);
      b = (k == 1) || (k == 2);
      @(negedge clk);
      checks++;
      if ({MulBusy, StallE, FlushM, FlushE, StallD} !== {b, b, b, ~b, 1'b1}) begin
        errors++;
        $display("FAIL mul_cycle_%0d: got %b want %b", k,
                 {MulBusy, StallE, FlushM, FlushE, StallD}, {b, b, b, ~b, 1'b1});
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_mul();
    for (int d = 1; d <= 2; d++) begin
      do_reset();
      MulStartE = 1'b1;
      tick();
      MulStartE = 1'b0;
      if (d == 2) tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({MulBusy, StallE, FlushD, FlushE} !== 4'b0011 || StallCycles !== '0) begin
        errors++;
        $display("FAIL mul_reset_during_%0d: got %b cnt=%0d want 0011 cnt=0", d,
                 {MulBusy, StallE, FlushD, FlushE}, StallCycles);
      end
      tick();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (MulBusy !== 1'b0 || StallCycles !== '0) begin
        errors++;
        $display("FAIL mul_reset_after_%0d: got busy=%b cnt=%0d want busy=0 cnt=0", d, MulBusy, StallCycles);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    PCSrcD = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 14 || i == 20 || i == 21) begin
        @(negedge clk);
        checks++;
        if (int'(StallCycles) != ((i < SAT) ? i : SAT)) begin
          errors++;
          $display("FAIL stall_sat_%0d: got %0d want %0d", i, StallCycles, (i < SAT) ? i : SAT);
        end
      end
    end
    idle();
  endtask

  function automatic logic [3:0] rnd_reg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [3:0] src);
    if (src == 4'd15)                    return 2'b00;
    if (RegWriteM && (WA3M == src))      return 2'b10;
    if (RegWriteW && (WA3W == src))      return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_random();
    int   mul_left;
    int   stalls;
    logic m_busy, m_ldr, m_pend, m_sf;
    logic [10:0] exp_v;
    logic [10:0] got_v;
    int   exp_cnt;
    do_reset();
    mul_left = 0;
    stalls   = 0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 29) != 0);
      RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
      WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 2) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0);
      PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0);
      PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MulStartE = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      m_busy = reset && (mul_left > 0);
      m_ldr  = reset && MemtoRegE && RegWriteE && (WA3E != 4'd15) && (RA1D == WA3E || RA2D == WA3E);
      m_pend = reset && (PCSrcD || PCSrcE || PCSrcM);
      m_sf   = m_ldr || m_pend || m_busy;
      exp_v = {m_sf, m_ldr || m_busy, m_busy,
               !reset || m_pend || PCSrcW || BranchTakenE,
               !reset || ((m_ldr || BranchTakenE) && !m_busy),
               m_busy,
               reset ? model_fwd(RA1E) : 2'b00,
               reset ? model_fwd(RA2E) : 2'b00,
               m_busy};
      got_v = {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, MulBusy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rand_outputs_%0d: got %b want %b", c, got_v, exp_v);
      end
      exp_cnt = reset ? stalls : 0;
      checks++;
      if (int'(StallCycles) != exp_cnt || $isunknown(StallCycles)) begin
        errors++;
        $display("FAIL rand_stall_cycles_%0d: got %0d want %0d", c, StallCycles, exp_cnt);
      end
      if (!reset) begin
        mul_left = 0;
        stalls   = 0;
      end else begin
        if (m_sf && stalls < SAT) stalls++;
        if (mul_left > 0)                        mul_left--;
        else if (MulStartE && MUL_LAT > 1)       mul_left = int'(MUL_LAT) - 1;
      end
      tick();
    end
    reset = 1'b1;
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multiply();
    test_reset_mid_mul();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
